// File: rtl/kbms_event_queue_pkg.sv
// Shared definitions for the keyboard/mouse event queue: register map,
// STATUS bit layout and default FIFO depth.
package kbms_event_queue_pkg;

  localparam int KB_DEPTH_DEFAULT = 8;

  localparam int BUS_W    = 16;
  localparam int MS_W     = 12;
  localparam int MS_BTN_W = 3;

  typedef enum logic [1:0] {
    REG_KBDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_MSX    = 2'd2,
    REG_MSY    = 2'd3
  } reg_addr_e;

  localparam int ST_KB_NONEMPTY = 0;
  localparam int ST_MS_NEW      = 1;
  localparam int ST_KB_OVF      = 2;
  localparam int ST_COUNT_LO    = 4;
  localparam int ST_COUNT_HI    = 7;
  localparam int ST_KB_IE       = 8;
  localparam int ST_MS_IE       = 9;

  // Buttons sit above a zero gap bit so the x field stays right-aligned.
  function automatic logic [BUS_W-1:0] pack_msx(input logic [MS_BTN_W-1:0] btn,
                                                input logic [MS_W-1:0]     x);
    return {btn, 1'b0, x};
  endfunction

  function automatic logic [BUS_W-1:0] pack_msy(input logic [MS_W-1:0] y);
    return {{(BUS_W-MS_W){1'b0}}, y};
  endfunction

endpackage

// File: rtl/kbms_event_queue_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head and occupancy count.
// Push and pop in one cycle are both honoured, including when full.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];

  // A pop frees the slot the simultaneous push lands in, so full is no obstacle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/kbms_event_queue.sv
// Keyboard/mouse event queue: keyboard words into a FIFO, latest mouse sample
// in registers, all exposed through a four-register bus with level irq.
module kbms_event_queue
  import kbms_event_queue_pkg::*;
#(
  parameter int KB_DEPTH = KB_DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUS_W-1:0]    kb_data,
  input  logic                kb_ready,
  input  logic [MS_W-1:0]     ms_x,
  input  logic [MS_W-1:0]     ms_y,
  input  logic [MS_BTN_W-1:0] ms_button,
  input  logic                ms_ready,
  input  logic [1:0]          bus_addr,
  input  logic                bus_rd,
  input  logic                bus_wr,
  input  logic [BUS_W-1:0]    bus_wdata,
  output logic [BUS_W-1:0]    bus_rdata,
  output logic                bus_ack,
  output logic                irq
);

  localparam int CW = $clog2(KB_DEPTH) + 1;

  logic                r_kb_ready_d;
  logic                r_ms_ready_d;
  logic                r_kb_ovf;
  logic                r_ms_new;
  logic                r_kb_ie;
  logic                r_ms_ie;
  logic [MS_W-1:0]     r_ms_x;
  logic [MS_W-1:0]     r_ms_y;
  logic [MS_BTN_W-1:0] r_ms_btn;
  logic [MS_W-1:0]     r_y_shadow;
  logic [BUS_W-1:0]    r_bus_rdata;
  logic                r_bus_ack;
  logic                r_irq;

  logic                w_kb_rise;
  logic                w_ms_rise;
  logic                w_wr;
  logic                w_rd;
  logic                w_push_req;
  logic                w_pop_req;
  logic                w_kb_drop;
  logic                w_wr_status;
  logic                w_rd_msx;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CW-1:0]       w_fifo_count;
  logic [BUS_W-1:0]    w_fifo_head;
  logic [BUS_W-1:0]    w_status;
  logic [BUS_W-1:0]    w_rd_data;
  logic                w_unused_wdata;

  function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
    if (32'(c) > 32'd15) return 4'hF;
    else                 return 4'(c);
  endfunction

  function automatic logic [BUS_W-1:0] status_word(input logic          nonempty,
                                                   input logic          ms_new,
                                                   input logic          ovf,
                                                   input logic [CW-1:0] cnt,
                                                   input logic          kb_ie,
                                                   input logic          ms_ie);
    logic [BUS_W-1:0] s;
    s                           = '0;
    s[ST_KB_NONEMPTY]           = nonempty;
    s[ST_MS_NEW]                = ms_new;
    s[ST_KB_OVF]                = ovf;
    s[ST_COUNT_HI:ST_COUNT_LO]  = sat_count(cnt);
    s[ST_KB_IE]                 = kb_ie;
    s[ST_MS_IE]                 = ms_ie;
    return s;
  endfunction

  // Edge detection against the previous cycle's ready levels.
  assign w_kb_rise   = kb_ready & ~r_kb_ready_d;
  assign w_ms_rise   = ms_ready & ~r_ms_ready_d;

  // A simultaneous read and write is treated as a write alone.
  assign w_wr        = bus_wr;
  assign w_rd        = bus_rd & ~bus_wr;

  assign w_push_req  = w_kb_rise & ~reset;
  assign w_pop_req   = w_rd & (bus_addr == REG_KBDATA) & ~reset;
  assign w_kb_drop   = w_push_req & w_fifo_full & ~w_pop_req;
  assign w_wr_status = w_wr & (bus_addr == REG_STATUS);
  assign w_rd_msx    = w_rd & (bus_addr == REG_MSX);

  assign w_unused_wdata = ^{bus_wdata[15:10], bus_wdata[7:3], bus_wdata[1:0]};

  sync_fifo #(
    .DATA_W (BUS_W),
    .DEPTH  (KB_DEPTH)
  ) u_kb_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_req),
    .i_pop   (w_pop_req),
    .i_wdata (kb_data),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_status = status_word(~w_fifo_empty, r_ms_new, r_kb_ovf, w_fifo_count,
                                r_kb_ie, r_ms_ie);

  always_comb begin
    w_rd_data = '0;
    case (reg_addr_e'(bus_addr))
      REG_KBDATA: w_rd_data = w_fifo_empty ? '0 : w_fifo_head;
      REG_STATUS: w_rd_data = w_status;
      REG_MSX:    w_rd_data = pack_msx(r_ms_btn, r_ms_x);
      REG_MSY:    w_rd_data = pack_msy(r_y_shadow);
      default:    w_rd_data = '0;
    endcase
  end

  // Stage boundary: bus response, status flags and mouse capture registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kb_ready_d <= 1'b0;
      r_ms_ready_d <= 1'b0;
      r_kb_ovf     <= 1'b0;
      r_ms_new     <= 1'b0;
      r_kb_ie      <= 1'b0;
      r_ms_ie      <= 1'b0;
      r_ms_x       <= '0;
      r_ms_y       <= '0;
      r_ms_btn     <= '0;
      r_y_shadow   <= '0;
      r_bus_rdata  <= '0;
      r_bus_ack    <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_kb_ready_d <= kb_ready;
      r_ms_ready_d <= ms_ready;

      r_bus_ack    <= bus_rd | bus_wr;
      r_bus_rdata  <= w_rd ? w_rd_data : '0;

      if (w_wr_status) begin
        r_kb_ie <= bus_wdata[ST_KB_IE];
        r_ms_ie <= bus_wdata[ST_MS_IE];
      end

      // A fresh drop outranks a clear issued in the same cycle.
      if (w_kb_drop)
        r_kb_ovf <= 1'b1;
      else if (w_wr_status && bus_wdata[ST_KB_OVF])
        r_kb_ovf <= 1'b0;

      if (w_rd_msx)
        r_y_shadow <= r_ms_y;

      // The read sees the old sample; a coincident capture then re-arms ms_new.
      if (w_ms_rise) begin
        r_ms_x   <= ms_x;
        r_ms_y   <= ms_y;
        r_ms_btn <= ms_button;
        r_ms_new <= 1'b1;
      end else if (w_rd_msx) begin
        r_ms_new <= 1'b0;
      end

      r_irq <= (r_kb_ie & ~w_fifo_empty) | (r_ms_ie & r_ms_new);
    end
  end

  assign bus_rdata = r_bus_rdata;
  assign bus_ack   = r_bus_ack;
  assign irq       = r_irq;

endmodule

// File: tb/tb_kbms_event_queue.sv
// Directed bench for kbms_event_queue: keyboard FIFO, mouse registers,
// STATUS/CTRL, irq and reset behaviour against hand-computed values.
module tb_kbms_event_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] kb_data;
  logic        kb_ready;
  logic [11:0] ms_x;
  logic [11:0] ms_y;
  logic [2:0]  ms_button;
  logic        ms_ready;
  logic [1:0]  bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  kbms_event_queue #(.KB_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .kb_data   (kb_data),
    .kb_ready  (kb_ready),
    .ms_x      (ms_x),
    .ms_y      (ms_y),
    .ms_button (ms_button),
    .ms_ready  (ms_ready),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag, input logic [15:0] exp);
    bus_addr = a;
    bus_rd   = 1'b1;
    tick();
    bus_rd   = 1'b0;
    check({tag, "_ack"}, {15'b0, bus_ack}, 16'h0001);
    check(tag, bus_rdata, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d, input string tag);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    tick();
    bus_wr    = 1'b0;
    check({tag, "_ack"}, {15'b0, bus_ack}, 16'h0001);
    check({tag, "_rdata"}, bus_rdata, 16'h0000);
  endtask

  task automatic kb_push(input logic [15:0] d);
    kb_data  = d;
    kb_ready = 1'b1;
    tick();
    kb_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; kb_data = '0; kb_ready = 1'b0;
    ms_x = '0; ms_y = '0; ms_button = '0; ms_ready = 1'b0;
    bus_addr = '0; bus_rd = 1'b0; bus_wr = 1'b0; bus_wdata = '0;
    tick(); tick();
    check("rst_ack",   {15'b0, bus_ack}, 16'h0000);
    check("rst_rdata", bus_rdata, 16'h0000);
    check("rst_irq",   {15'b0, irq}, 16'h0000);
    reset = 1'b0;
    tick();
    bus_read(2'd1, "rst_status", 16'h0000);

    // Single keyboard word, then idle bus must show no ack and zero data.
    kb_data = 16'h1234; kb_ready = 1'b1;
    tick();
    kb_ready = 1'b0;
    bus_read(2'd0, "kb_single", 16'h1234);
    bus_read(2'd1, "kb_single_status", 16'h0000);
    tick();
    check("idle_ack",   {15'b0, bus_ack}, 16'h0000);
    check("idle_rdata", bus_rdata, 16'h0000);

    // Held kb_ready pushes once.
    kb_data = 16'h0055; kb_ready = 1'b1;
    tick(); tick(); tick();
    kb_ready = 1'b0;
    tick();
    bus_read(2'd1, "held_status", 16'h0011);
    bus_read(2'd0, "held_pop", 16'h0055);

    // Overflow: nine pushes into depth 8.
    for (int i = 1; i <= 9; i++) kb_push(16'(i));
    bus_read(2'd1, "ovf_status", 16'h0085);
    for (int i = 1; i <= 8; i++) bus_read(2'd0, $sformatf("ovf_pop%0d", i), 16'(i));
    bus_read(2'd1, "ovf_drained", 16'h0004);
    bus_write(2'd1, 16'h0004, "ovf_clr");
    bus_read(2'd1, "ovf_cleared", 16'h0000);

    // Empty pop returns zero and leaves count at zero.
    bus_read(2'd0, "empty_pop", 16'h0000);
    bus_read(2'd1, "empty_status", 16'h0000);

    // Mouse sample and coherent x/y read.
    ms_x = 12'h123; ms_y = 12'h456; ms_button = 3'b101; ms_ready = 1'b1;
    tick();
    ms_ready = 1'b0;
    bus_read(2'd1, "ms_status", 16'h0002);
    bus_read(2'd2, "ms_x", 16'hA123);
    bus_read(2'd3, "ms_y", 16'h0456);
    bus_read(2'd1, "ms_status_clr", 16'h0000);

    // Capture coincident with an x read: old x returned, ms_new ends set.
    ms_x = 12'h777; ms_y = 12'h888; ms_button = 3'b000; ms_ready = 1'b1;
    bus_addr = 2'd2; bus_rd = 1'b1;
    tick();
    bus_rd = 1'b0; ms_ready = 1'b0;
    check("coinc_x", bus_rdata, 16'hA123);
    bus_read(2'd1, "coinc_status", 16'h0002);
    bus_read(2'd3, "coinc_y_old", 16'h0456);
    bus_read(2'd2, "coinc_x_new", 16'h0777);
    bus_read(2'd3, "coinc_y_new", 16'h0888);

    // Keyboard interrupt.
    bus_write(2'd1, 16'h0100, "ie_set");
    check("irq_idle", {15'b0, irq}, 16'h0000);
    kb_push(16'hBEEF);
    check("irq_set", {15'b0, irq}, 16'h0001);
    bus_read(2'd0, "irq_pop", 16'hBEEF);
    check("irq_still", {15'b0, irq}, 16'h0001);
    tick();
    check("irq_clr", {15'b0, irq}, 16'h0000);
    bus_write(2'd1, 16'h0000, "ie_clr");

    // Simultaneous push and pop on a full FIFO.
    for (int i = 0; i < 8; i++) kb_push(16'h0010 + 16'(i));
    bus_read(2'd1, "full_status", 16'h0081);
    kb_data = 16'h0018; kb_ready = 1'b1;
    bus_addr = 2'd0; bus_rd = 1'b1;
    tick();
    kb_ready = 1'b0; bus_rd = 1'b0;
    check("pp_data", bus_rdata, 16'h0010);
    bus_read(2'd1, "pp_status", 16'h0081);
    for (int i = 1; i <= 8; i++) bus_read(2'd0, $sformatf("pp_pop%0d", i), 16'h0010 + 16'(i));
    bus_read(2'd1, "pp_drained", 16'h0000);

    // Read and write together: write only, so no pop.
    kb_push(16'h0099);
    bus_addr = 2'd0; bus_wdata = 16'hFFFF; bus_rd = 1'b1; bus_wr = 1'b1;
    tick();
    bus_rd = 1'b0; bus_wr = 1'b0;
    check("rdwr_ack", {15'b0, bus_ack}, 16'h0001);
    check("rdwr_rdata", bus_rdata, 16'h0000);
    bus_read(2'd1, "rdwr_status", 16'h0011);
    bus_read(2'd0, "rdwr_pop", 16'h0099);

    // Reset during an access suppresses its ack and clears state.
    bus_write(2'd1, 16'h0300, "ie_both");
    kb_push(16'h0042);
    bus_addr = 2'd0; bus_rd = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; bus_rd = 1'b0;
    check("rstmid_ack",   {15'b0, bus_ack}, 16'h0000);
    check("rstmid_rdata", bus_rdata, 16'h0000);
    check("rstmid_irq",   {15'b0, irq}, 16'h0000);
    bus_read(2'd1, "rstmid_status", 16'h0000);
    bus_read(2'd0, "rstmid_pop", 16'h0000);
    bus_read(2'd2, "rstmid_msx", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kbms_event_queue.md
KBMS_EVENT_QUEUE -- requirements
Module: kbms_event_queue

Interface
REQ-001 The block SHALL have parameter KB_DEPTH, default 8, which sets the keyboard FIFO depth in entries (a power of 2, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: system clock.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high; clock clk.
REQ-004 The block SHALL have ports kb_data (input, 16 bits) and kb_ready (input, 1 bit): keyboard word and its valid flag, from the PS/2 support stage.
REQ-005 The block SHALL have ports ms_x and ms_y (input, 12 bits each), ms_button (input, 3 bits, L/M/R = bits 2/1/0) and ms_ready (input, 1 bit): mouse sample and its valid flag.
REQ-006 The block SHALL have ports bus_addr (input, 2 bits), bus_rd (input, 1 bit), bus_wr (input, 1 bit) and bus_wdata (input, 16 bits): the register access request.
REQ-007 The block SHALL have ports bus_rdata (output, 16 bits) and bus_ack (output, 1 bit): read data and access acknowledge.
REQ-008 The block SHALL have port irq (output, 1 bit): level interrupt request.

Function
REQ-009 The block SHALL push kb_data into the FIFO on each rising edge of kb_ready (0->1, sampled against the previous cycle); a held-high kb_ready SHALL push only once.
REQ-010 A push when the FIFO is full SHALL drop the word and set sticky status bit kb_ovf.
REQ-011 On each rising edge of ms_ready the block SHALL capture ms_x, ms_y and ms_button into the mouse registers and set ms_new.
REQ-012 Register map:
- addr 0: KBDATA, read-pop.
- addr 1: STATUS/CTRL.
- addr 2: MSX = {ms_button, 1'b0, x}.
- addr 3: MSY = {4'b0, y_shadow}.
REQ-013 A read of addr 0 SHALL return the FIFO head and pop it; when the FIFO is empty it SHALL return 16'h0000 and leave the pointers unchanged.
REQ-014 STATUS read bits SHALL be:
- bit0: kb_nonempty
- bit1: ms_new
- bit2: kb_ovf
- bits7:4: FIFO count, saturated at 15
- bit8: kb_ie
- bit9: ms_ie
- all other bits: 0
REQ-015 A write to addr 1 SHALL load kb_ie from bit8 and ms_ie from bit9, and SHALL clear kb_ovf when bit2 = 1 (write-1-to-clear).
REQ-016 A read of addr 2 SHALL copy the current y into y_shadow and clear ms_new, so that a following read of addr 3 returns y coherent with the x just read.
REQ-017 Writes to addr 0, 2 and 3 SHALL be ignored and acknowledged.
REQ-018 Each cycle with bus_rd or bus_wr high SHALL produce bus_ack = 1 exactly one cycle later, with bus_rdata valid in that same cycle; bus_rdata SHALL be 0 when bus_ack = 0.
REQ-019 When bus_rd and bus_wr are high together, the block SHALL perform the write only.
REQ-020 Push and pop in the same cycle SHALL both take effect and leave count unchanged; on a full FIFO the push SHALL then succeed, with no overflow.
REQ-021 A push into an empty FIFO SHALL be readable by a pop issued in the next cycle, giving one-cycle latency.
REQ-022 When a mouse capture coincides with an addr 2 read, the read SHALL return the old x, the capture SHALL then take effect, and ms_new SHALL end at 1.
REQ-023 irq SHALL be registered and equal (kb_ie & kb_nonempty) | (ms_ie & ms_new), one cycle after the state change.
REQ-024 FIFO pointers SHALL wrap modulo KB_DEPTH, and the count SHALL be held at log2(KB_DEPTH)+1 bits.

Reset
REQ-025 Reset SHALL clear:
- FIFO pointers and count
- kb_ovf, ms_new, kb_ie, ms_ie
- mouse registers and y_shadow
- edge-detect history
- bus_ack, bus_rdata, irq
REQ-026 Reset SHALL take priority over any simultaneous push, pop or bus access, and reset in the middle of an access SHALL suppress its bus_ack.

Structure
REQ-027 A shared package SHALL hold the register addresses, the STATUS bit positions and the KB_DEPTH default.
REQ-028 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised in width and depth, exposing push, pop, full, empty and count.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Pulse kb_ready with kb_data = 16'h1234, then read addr 0 -> bus_ack one cycle later and rdata = 16'h1234; STATUS bit0 = 0 afterwards.
- Push 9 words 1..9 into a depth-8 FIFO -> STATUS = count 8 with kb_ovf = 1; eight pops return 1..8; write STATUS bit2 = 1 -> kb_ovf = 0.
- Read addr 0 with the FIFO empty -> rdata = 0 and count stays 0.
- Mouse x = 12'h123, y = 12'h456, buttons = 3'b101, then read addr 2 and addr 3 -> 16'hA123 and 16'h0456; ms_new = 0.
- Set kb_ie, push one word -> irq = 1; pop it -> irq = 0 the following cycle.
- Push and pop in the same cycle on a full FIFO -> count stays 8, kb_ovf = 0, data order preserved.
